bp_burst_to_xui_pipelined: RTL and testbench
============================================

# bp_burst_to_xui_pipelined

Bridges the BedRock CCE memory burst interface (header + dword data beats) to a Xilinx MIG user interface (XUI), between the CCE memory port and the DDR controller on FPGA test harnesses. Next-generation bridge: parametrised XUI burst length, multiple outstanding reads, credit-reserved read-return buffering (XUI read data cannot be back-pressured), and in-order write acknowledgements.

## Interface
- bp_params_p, e_bp_default_cfg: processor config; supplies paddr_width_p, dword_width_p, cce_block_width_p and the mem header layout.
- xui_burst_len_p, cce_block_width_p/dword_width_p: XUI beats per app command; power of two, ≥ 1.
- rd_outstanding_p, 4: maximum reads issued to XUI but not fully returned.
- rd_buf_els_p, 2*xui_burst_len_p: read-return buffer depth in dwords; ≥ xui_burst_len_p.
- clk_i  in  1  sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- mem_cmd_header_i / _v_i / _ready_o  in/in/out  cce_mem_msg_header_width_lp/1/1  command header, ready-valid.
- mem_cmd_data_i / _v_i / _ready_o  in/in/out  dword_width_p/1/1  write data beats, ready-valid.
- mem_resp_header_o / _v_o / _yumi_i  out/out/in  header width/1/1  response header, valid-yumi.
- mem_resp_data_o / _v_o / _yumi_i  out/out/in  dword_width_p/1/1  read data beats, valid-yumi.
- app_addr_o  out  paddr_width_p  header addr, unmodified.
- app_cmd_o  out  app_cmd_e  e_read for e_bedrock_mem_rd/uc_rd, else e_write.
- app_en_o / app_rdy_i  out/in  1/1  XUI command handshake.
- app_wdf_wren_o, app_wdf_end_o  out  1 each  write-data strobe, last beat of burst.
- app_wdf_data_o  out  dword_width_p; app_wdf_mask_o  out  dword_width_p/8 (1 = byte not written).
- app_wdf_rdy_i, app_rd_data_valid_i, app_rd_data_end_i  in  1 each.
- app_rd_data_i  in  dword_width_p.

## Operation
- Valid beats per message: beats_lo = (2^size < dword bytes) ? 1 : 2^size / dword bytes, capped at xui_burst_len_p.
- Command FSM: e_idle, e_rd_issue, e_wr_issue, e_wr_data, e_wr_pad.
- e_idle: accepts a header (ready_o = 1) only in this state; latch it; go to e_rd_issue or e_wr_issue.
- e_rd_issue: app_en_o = 1 only when read-tag FIFO not full and free buffer credits ≥ beats_lo; on app_en_o & app_rdy_i reserve beats_lo credits, push {header, beats_lo} into read-tag FIFO and in-flight FIFO, return to e_idle.
- e_wr_issue: app_en_o = 1; on accept go to e_wr_data.
- e_wr_data: mem_cmd_data_ready_o = app_wdf_rdy_i; each transfer drives wren, mask 0. After beat beats_lo: if beats_lo = xui_burst_len_p assert end on that beat, push header to in-flight FIFO, go e_idle; else go e_wr_pad.
- e_wr_pad: wren = app_wdf_rdy_i, data 0, mask all ones, until beat xui_burst_len_p (end asserted), then push header, go e_idle.
- Read receive: counter rx_cnt over app_rd_data_valid_i beats, wrapping at xui_burst_len_p; beat written to buffer iff rx_cnt < head-of-read-tag beats_lo; read-tag FIFO popped on beat xui_burst_len_p-1.
- Response side: head of in-flight FIFO. Write: header valid, pop on yumi. Read: header valid until yumi; then mem_resp_data_v_o = buffer non-empty; pop in-flight after beats_lo data yumis; each data yumi returns one credit.
- Responses strictly in command order.

## Timing
- All outputs 0 in reset (ready_o, v_o, app_en_o, wren, end 0; credits = rd_buf_els_p; FIFOs empty; FSM e_idle). Reset mid-burst abandons the burst; no recovery.
- Header accept → app_en_o next cycle (registered FSM).
- XUI read beat → buffer → mem_resp_data_v_o next cycle at earliest.
- Write ack header valid cycle after wdf_end beat.
- Simultaneous credit return and reservation in one cycle: net update.
- Data beat accepted and yumi'd in same cycle on full buffer impossible by credit rule; buffer overflow is a fatal error.

## Configuration
- BP_BURST_TO_XUI_STATS_EN: adds outputs rd_cmds_o, wr_cmds_o (32 bits each, saturating counts of accepted app commands) and stall_cycles_o (cycles in e_rd_issue blocked by credits/tags). Without it these ports and counters do not exist.

## Structure
- Shared package bp_me_pkg: FSM enum, read-tag struct {beats_lo}; app_cmd_e stays in bsg_dmc_pkg.
- Sub-module bp_xui_rd_return: rx counter, read-tag FIFO, buffer, credit counter.
- Reuse bsg_fifo_1r1w_small for in-flight/tag FIFOs and buffer.

## Test plan
- Read, size 64B, burst 8, dword 64 → 8 beats returned in order, header once, credits back to 16.
- Uncached read, size 8B → one data beat; XUI beats 1-7 dropped; app_wdf never asserted.
- Write 8B → 1 data beat mask 0, 7 pad beats mask 0xFF, end on beat 8, then ack header.
- Four 64B reads back-to-back, resp_data_yumi_i held 0 → third issue stalls on credits; releasing yumi drains in order.
- Write then read to same address → write ack before read header; read data equals written data.
- Reset asserted mid-write pad → all outputs 0 same cycle (async), FSM e_idle after release.

Source files
------------

// File: rtl/bp_burst_to_xui_pipelined_pkg.sv
// Shared types for the BedRock burst to Xilinx XUI bridge: message header layout,
// command FSM states, read-tag and in-flight entries, and the beat-count helper.
package bp_burst_to_xui_pipelined_pkg;

  localparam int PADDR_W     = 40;
  localparam int DWORD_W     = 64;
  localparam int BLOCK_W     = 512;
  localparam int DWORD_BYTES = DWORD_W / 8;
  localparam int CNT_W       = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bedrock_msg_e;

  typedef struct packed {
    bedrock_msg_e       msg_type;
    logic [2:0]         size;
    logic [PADDR_W-1:0] addr;
  } mem_header_s;

  localparam int HDR_W = $bits(mem_header_s);

  typedef enum logic [2:0] {
    e_idle     = 3'd0,
    e_rd_issue = 3'd1,
    e_wr_issue = 3'd2,
    e_wr_data  = 3'd3,
    e_wr_pad   = 3'd4
  } cmd_state_e;

  typedef enum logic [2:0] {
    e_write = 3'b000,
    e_read  = 3'b001
  } app_cmd_e;

  typedef struct packed {
    cnt_t beats_lo;
  } rd_tag_s;

  typedef struct packed {
    mem_header_s hdr;
    cnt_t        beats_lo;
  } ifl_entry_s;

  // Dwords carrying payload for a message of 2^size bytes, capped at the XUI burst.
  function automatic cnt_t calc_beats(input logic [2:0] size, input int burst_len);
    int bytes;
    int beats;
    bytes = 1 << size;
    beats = (bytes < DWORD_BYTES) ? 1 : bytes / DWORD_BYTES;
    if (beats > burst_len) begin
      beats = burst_len;
    end else begin
      beats = beats;
    end
    return cnt_t'(beats);
  endfunction

  function automatic logic is_read(input mem_header_s h);
    return (h.msg_type == e_bedrock_mem_rd) || (h.msg_type == e_bedrock_mem_uc_rd);
  endfunction

endpackage

// File: rtl/bp_burst_to_xui_pipelined_fifo.sv
// Small one-read one-write FIFO with ready-valid push and valid-yumi pop;
// depth need not be a power of two.
module bp_burst_to_xui_pipelined_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rptr_q, wptr_q;
  logic [cnt_w_lp-1:0] cnt_q;
  logic                push_s, pop_s;

  function automatic logic [ptr_w_lp-1:0] ptr_incr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign full_o = (cnt_q == cnt_w_lp'(els_p));
  assign v_o    = (cnt_q != '0);
  assign data_o = mem_q[rptr_q];
  assign push_s = v_i & ~full_o;
  assign pop_s  = yumi_i & v_o;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_incr(wptr_q);
      end
      if (pop_s) begin
        rptr_q <= ptr_incr(rptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + cnt_w_lp'(1);
        2'b01:   cnt_q <= cnt_q - cnt_w_lp'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bp_burst_to_xui_pipelined_rd_return.sv
// XUI read-return path: beat counter, read-tag FIFO, return buffer and buffer credits.
// Every buffered beat was credit-reserved at issue, since XUI read data cannot stall.
module bp_burst_to_xui_pipelined_rd_return
  import bp_burst_to_xui_pipelined_pkg::*;
#(
  parameter int xui_burst_len_p  = 8,
  parameter int rd_outstanding_p = 4,
  parameter int rd_buf_els_p     = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               tag_v_i,
  input  cnt_t               tag_beats_i,
  output logic               tag_full_o,
  output cnt_t               credits_o,
  input  logic               app_rd_data_valid_i,
  input  logic               app_rd_data_end_i,
  input  logic [DWORD_W-1:0] app_rd_data_i,
  output logic               data_v_o,
  output logic [DWORD_W-1:0] data_o,
  input  logic               data_yumi_i
);

  cnt_t    rx_cnt_q, rx_cnt_d;
  cnt_t    credits_q, credits_d;
  rd_tag_s tag_head_s;
  logic    tag_v_s, tag_pop_s, rx_last_s;
  logic    buf_wr_s, buf_full_s, ret_s;

  bp_burst_to_xui_pipelined_fifo #(.width_p($bits(rd_tag_s)), .els_p(rd_outstanding_p)) u_tag_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (tag_v_i),
    .data_i (rd_tag_s'(tag_beats_i)),
    .full_o (tag_full_o),
    .v_o    (tag_v_s),
    .data_o (tag_head_s),
    .yumi_i (tag_pop_s)
  );

  bp_burst_to_xui_pipelined_fifo #(.width_p(DWORD_W), .els_p(rd_buf_els_p)) u_buf_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (buf_wr_s),
    .data_i (app_rd_data_i),
    .full_o (buf_full_s),
    .v_o    (data_v_o),
    .data_o (data_o),
    .yumi_i (data_yumi_i)
  );

  // The controller's end flag resynchronises the beat counter should it ever drift.
  assign rx_last_s = (rx_cnt_q == cnt_t'(xui_burst_len_p - 1)) | app_rd_data_end_i;
  assign buf_wr_s  = app_rd_data_valid_i & tag_v_s & (rx_cnt_q < tag_head_s.beats_lo) & ~buf_full_s;
  assign tag_pop_s = app_rd_data_valid_i & rx_last_s;
  assign ret_s     = data_yumi_i & data_v_o;
  assign credits_o = credits_q;

  // Next beat index within the current XUI burst.
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (app_rd_data_valid_i) begin
      rx_cnt_d = rx_last_s ? '0 : rx_cnt_q + cnt_t'(1);
    end else begin
      rx_cnt_d = rx_cnt_q;
    end
  end

  // Reservation at issue and return on consumption may coincide; apply both.
  always_comb begin
    credits_d = credits_q + cnt_t'(ret_s) - (tag_v_i ? tag_beats_i : cnt_t'(0));
  end

  // Beat counter and credit registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_cnt_q  <= '0;
      credits_q <= cnt_t'(rd_buf_els_p);
    end else begin
      rx_cnt_q  <= rx_cnt_d;
      credits_q <= credits_d;
    end
  end

endmodule

// File: rtl/bp_burst_to_xui_pipelined.sv
// BedRock memory burst to Xilinx MIG XUI bridge with pipelined reads and in-order responses.
// Define BP_BURST_TO_XUI_STATS_EN to add command and stall counters.
module bp_burst_to_xui_pipelined
  import bp_burst_to_xui_pipelined_pkg::*;
#(
  parameter int xui_burst_len_p  = BLOCK_W / DWORD_W,
  parameter int rd_outstanding_p = 4,
  parameter int rd_buf_els_p     = 2 * xui_burst_len_p
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [HDR_W-1:0]     mem_cmd_header_i,
  input  logic                 mem_cmd_header_v_i,
  output logic                 mem_cmd_header_ready_o,
  input  logic [DWORD_W-1:0]   mem_cmd_data_i,
  input  logic                 mem_cmd_data_v_i,
  output logic                 mem_cmd_data_ready_o,
  output logic [HDR_W-1:0]     mem_resp_header_o,
  output logic                 mem_resp_header_v_o,
  input  logic                 mem_resp_header_yumi_i,
  output logic [DWORD_W-1:0]   mem_resp_data_o,
  output logic                 mem_resp_data_v_o,
  input  logic                 mem_resp_data_yumi_i,
  output logic [PADDR_W-1:0]   app_addr_o,
  output app_cmd_e             app_cmd_o,
  output logic                 app_en_o,
  input  logic                 app_rdy_i,
  output logic                 app_wdf_wren_o,
  output logic [DWORD_W-1:0]   app_wdf_data_o,
  output logic [DWORD_W/8-1:0] app_wdf_mask_o,
  output logic                 app_wdf_end_o,
  input  logic                 app_wdf_rdy_i,
  input  logic [DWORD_W-1:0]   app_rd_data_i,
  input  logic                 app_rd_data_end_i,
  input  logic                 app_rd_data_valid_i
`ifdef BP_BURST_TO_XUI_STATS_EN
  ,
  output logic [31:0]          rd_cmds_o,
  output logic [31:0]          wr_cmds_o,
  output logic [31:0]          stall_cycles_o
`endif
);

  localparam int ifl_els_lp = rd_outstanding_p + 2;

  cmd_state_e  state_q, state_d;
  mem_header_s hdr_q, hdr_d, hdr_in_s;
  cnt_t        beats_q, beats_d, wcnt_q, wcnt_d, dcnt_q, dcnt_d;
  logic        hdr_sent_q, hdr_sent_d;
  logic        tag_push_s, ifl_push_s, ifl_pop_s, ifl_full_s, ifl_v_s;
  logic        tag_full_s, buf_v_s, data_yumi_s, head_is_rd_s;
  cnt_t        credits_s;
  ifl_entry_s  ifl_head_s;

  assign hdr_in_s   = mem_header_s'(mem_cmd_header_i);
  assign app_addr_o = hdr_q.addr;
  assign app_cmd_o  = is_read(hdr_q) ? e_read : e_write;

  // Command FSM: header intake, app command issue and write-data/pad beats.
  always_comb begin
    state_d                = state_q;
    hdr_d                  = hdr_q;
    beats_d                = beats_q;
    wcnt_d                 = wcnt_q;
    mem_cmd_header_ready_o = 1'b0;
    mem_cmd_data_ready_o   = 1'b0;
    app_en_o               = 1'b0;
    app_wdf_wren_o         = 1'b0;
    app_wdf_end_o          = 1'b0;
    app_wdf_data_o         = '0;
    app_wdf_mask_o         = '0;
    tag_push_s             = 1'b0;
    ifl_push_s             = 1'b0;
    case (state_q)
      e_idle: begin
        mem_cmd_header_ready_o = ~ifl_full_s & ~reset_i;
        if (mem_cmd_header_ready_o & mem_cmd_header_v_i) begin
          hdr_d   = hdr_in_s;
          beats_d = calc_beats(hdr_in_s.size, xui_burst_len_p);
          wcnt_d  = '0;
          state_d = is_read(hdr_in_s) ? e_rd_issue : e_wr_issue;
        end else begin
          state_d = e_idle;
        end
      end
      e_rd_issue: begin
        app_en_o = ~tag_full_s & (credits_s >= beats_q);
        if (app_en_o & app_rdy_i) begin
          tag_push_s = 1'b1;
          ifl_push_s = 1'b1;
          state_d    = e_idle;
        end else begin
          state_d = e_rd_issue;
        end
      end
      e_wr_issue: begin
        app_en_o = 1'b1;
        state_d  = app_rdy_i ? e_wr_data : e_wr_issue;
      end
      e_wr_data: begin
        mem_cmd_data_ready_o = app_wdf_rdy_i;
        app_wdf_wren_o       = mem_cmd_data_v_i & app_wdf_rdy_i;
        app_wdf_data_o       = mem_cmd_data_i;
        if (app_wdf_wren_o) begin
          wcnt_d = wcnt_q + cnt_t'(1);
          if (wcnt_q == beats_q - cnt_t'(1)) begin
            if (beats_q == cnt_t'(xui_burst_len_p)) begin
              app_wdf_end_o = 1'b1;
              ifl_push_s    = 1'b1;
              state_d       = e_idle;
            end else begin
              state_d = e_wr_pad;
            end
          end else begin
            state_d = e_wr_data;
          end
        end else begin
          state_d = e_wr_data;
        end
      end
      e_wr_pad: begin
        app_wdf_wren_o = app_wdf_rdy_i;
        app_wdf_mask_o = '1;
        if (app_wdf_wren_o) begin
          wcnt_d = wcnt_q + cnt_t'(1);
          if (wcnt_q == cnt_t'(xui_burst_len_p - 1)) begin
            app_wdf_end_o = 1'b1;
            ifl_push_s    = 1'b1;
            state_d       = e_idle;
          end else begin
            state_d = e_wr_pad;
          end
        end else begin
          state_d = e_wr_pad;
        end
      end
      default: state_d = e_idle;
    endcase
  end

  // Command FSM registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      hdr_q   <= '0;
      beats_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      beats_q <= beats_d;
      wcnt_q  <= wcnt_d;
    end
  end

  bp_burst_to_xui_pipelined_fifo #(.width_p($bits(ifl_entry_s)), .els_p(ifl_els_lp)) u_ifl_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (ifl_push_s),
    .data_i ({hdr_q, beats_q}),
    .full_o (ifl_full_s),
    .v_o    (ifl_v_s),
    .data_o (ifl_head_s),
    .yumi_i (ifl_pop_s)
  );

  bp_burst_to_xui_pipelined_rd_return #(
    .xui_burst_len_p (xui_burst_len_p),
    .rd_outstanding_p(rd_outstanding_p),
    .rd_buf_els_p    (rd_buf_els_p)
  ) u_rd_return (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .tag_v_i            (tag_push_s),
    .tag_beats_i        (beats_q),
    .tag_full_o         (tag_full_s),
    .credits_o          (credits_s),
    .app_rd_data_valid_i(app_rd_data_valid_i),
    .app_rd_data_end_i  (app_rd_data_end_i),
    .app_rd_data_i      (app_rd_data_i),
    .data_v_o           (buf_v_s),
    .data_o             (mem_resp_data_o),
    .data_yumi_i        (data_yumi_s)
  );

  // Responses follow the in-flight FIFO head, so they leave in command order.
  assign head_is_rd_s        = is_read(ifl_head_s.hdr);
  assign mem_resp_header_o   = ifl_head_s.hdr;
  assign mem_resp_header_v_o = ifl_v_s & ~hdr_sent_q;
  assign mem_resp_data_v_o   = ifl_v_s & hdr_sent_q & buf_v_s;
  assign data_yumi_s         = mem_resp_data_yumi_i & mem_resp_data_v_o;

  // Response sequencing: header first, then beats_lo data beats for reads.
  always_comb begin
    hdr_sent_d = hdr_sent_q;
    dcnt_d     = dcnt_q;
    ifl_pop_s  = 1'b0;
    if (mem_resp_header_v_o & mem_resp_header_yumi_i) begin
      hdr_sent_d = head_is_rd_s;
      ifl_pop_s  = ~head_is_rd_s;
    end else if (data_yumi_s) begin
      if (dcnt_q == ifl_head_s.beats_lo - cnt_t'(1)) begin
        dcnt_d     = '0;
        hdr_sent_d = 1'b0;
        ifl_pop_s  = 1'b1;
      end else begin
        dcnt_d = dcnt_q + cnt_t'(1);
      end
    end else begin
      hdr_sent_d = hdr_sent_q;
    end
  end

  // Response sequencing registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_sent_q <= 1'b0;
      dcnt_q     <= '0;
    end else begin
      hdr_sent_q <= hdr_sent_d;
      dcnt_q     <= dcnt_d;
    end
  end

`ifdef BP_BURST_TO_XUI_STATS_EN
  logic [31:0] rd_cmds_q, wr_cmds_q, stall_q;

  assign rd_cmds_o      = rd_cmds_q;
  assign wr_cmds_o      = wr_cmds_q;
  assign stall_cycles_o = stall_q;

  // Saturating counts of accepted app commands and credit/tag stall cycles.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_cmds_q <= '0;
      wr_cmds_q <= '0;
      stall_q   <= '0;
    end else begin
      if (app_en_o & app_rdy_i & (state_q == e_rd_issue) & (rd_cmds_q != '1)) begin
        rd_cmds_q <= rd_cmds_q + 32'd1;
      end
      if (app_en_o & app_rdy_i & (state_q == e_wr_issue) & (wr_cmds_q != '1)) begin
        wr_cmds_q <= wr_cmds_q + 32'd1;
      end
      if ((state_q == e_rd_issue) & ~app_en_o & (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_burst_to_xui_pipelined.sv
// Directed self-checking bench for bp_burst_to_xui_pipelined with a behavioural XUI/DDR model.
module tb_bp_burst_to_xui_pipelined;
  import bp_burst_to_xui_pipelined_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 reset_i;
  logic [HDR_W-1:0]     mem_cmd_header_i;
  logic                 mem_cmd_header_v_i, mem_cmd_header_ready_o;
  logic [DWORD_W-1:0]   mem_cmd_data_i;
  logic                 mem_cmd_data_v_i, mem_cmd_data_ready_o;
  logic [HDR_W-1:0]     mem_resp_header_o;
  logic                 mem_resp_header_v_o, mem_resp_header_yumi_i;
  logic [DWORD_W-1:0]   mem_resp_data_o;
  logic                 mem_resp_data_v_o, mem_resp_data_yumi_i;
  logic [PADDR_W-1:0]   app_addr_o;
  app_cmd_e             app_cmd_o;
  logic                 app_en_o, app_rdy_i;
  logic                 app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
  logic [DWORD_W-1:0]   app_wdf_data_o, app_rd_data_i;
  logic [DWORD_W/8-1:0] app_wdf_mask_o;
  logic                 app_rd_data_end_i, app_rd_data_valid_i;
`ifdef BP_BURST_TO_XUI_STATS_EN
  logic [31:0]          rd_cmds_o, wr_cmds_o, stall_cycles_o;
`endif

  bp_burst_to_xui_pipelined dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .mem_cmd_header_i(mem_cmd_header_i), .mem_cmd_header_v_i(mem_cmd_header_v_i),
    .mem_cmd_header_ready_o(mem_cmd_header_ready_o),
    .mem_cmd_data_i(mem_cmd_data_i), .mem_cmd_data_v_i(mem_cmd_data_v_i),
    .mem_cmd_data_ready_o(mem_cmd_data_ready_o),
    .mem_resp_header_o(mem_resp_header_o), .mem_resp_header_v_o(mem_resp_header_v_o),
    .mem_resp_header_yumi_i(mem_resp_header_yumi_i),
    .mem_resp_data_o(mem_resp_data_o), .mem_resp_data_v_o(mem_resp_data_v_o),
    .mem_resp_data_yumi_i(mem_resp_data_yumi_i),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
    .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_data_o(app_wdf_data_o),
    .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_rdy_i(app_wdf_rdy_i), .app_rd_data_i(app_rd_data_i),
    .app_rd_data_end_i(app_rd_data_end_i), .app_rd_data_valid_i(app_rd_data_valid_i)
`ifdef BP_BURST_TO_XUI_STATS_EN
    , .rd_cmds_o(rd_cmds_o), .wr_cmds_o(wr_cmds_o), .stall_cycles_o(stall_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  m;
    logic        e;
  } wbeat_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cmds = 0;
  int          end_cyc = 0;
  int          wb = 0;
  logic        hy_en = 1'b1;
  logic        dy_en = 1'b1;
  logic [39:0] waddr = '0;
  logic [63:0] ddr [logic [39:0]];
  logic [39:0] rq [$];
  wbeat_t      wbeats [$];
  mem_header_s rhdr [$];
  int          hdr_cyc [$];
  logic [63:0] rdat [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [39:0] a);
    return {24'hC0FFEE, a};
  endfunction

  function automatic logic [63:0] ddr_rd(input logic [39:0] a);
    if (ddr.exists(a)) return ddr[a];
    return pat(a);
  endfunction

  function automatic mem_header_s mkhdr(input bedrock_msg_e t, input logic [2:0] sz, input logic [39:0] a);
    mem_header_s h;
    h.msg_type = t;
    h.size     = sz;
    h.addr     = a;
    return h;
  endfunction

  // Observe XUI and response handshakes away from the active edge.
  initial forever begin
    @(negedge clk_i);
    if (reset_i) begin
      wb = 0;
    end else begin
      if (app_en_o && app_rdy_i) begin
        if (app_cmd_o == e_read) begin
          rq.push_back(app_addr_o);
          rd_cmds++;
        end else begin
          waddr = app_addr_o;
          wb = 0;
        end
      end
      if (app_wdf_wren_o && app_wdf_rdy_i) begin
        logic [63:0] tmp;
        logic [39:0] a;
        wbeats.push_back('{app_wdf_data_o, app_wdf_mask_o, app_wdf_end_o});
        a = waddr + 40'(8 * wb);
        tmp = ddr_rd(a);
        for (int b = 0; b < 8; b++) if (!app_wdf_mask_o[b]) tmp[8*b +: 8] = app_wdf_data_o[8*b +: 8];
        ddr[a] = tmp;
        if (app_wdf_end_o) end_cyc = cyc;
        wb++;
      end
      if (mem_resp_header_v_o && mem_resp_header_yumi_i) begin
        rhdr.push_back(mem_header_s'(mem_resp_header_o));
        hdr_cyc.push_back(cyc);
      end
      if (mem_resp_data_v_o && mem_resp_data_yumi_i) rdat.push_back(mem_resp_data_o);
    end
  end

  // DDR read return: one full XUI burst per accepted read command.
  initial begin
    int          rbeat;
    logic        ractive;
    logic [39:0] raddr;
    rbeat = 0; ractive = 1'b0; raddr = '0;
    app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0; app_rd_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (!ractive && rq.size() > 0 && !reset_i) begin
        raddr = rq.pop_front();
        ractive = 1'b1;
        rbeat = 0;
      end
      if (ractive) begin
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i       = ddr_rd(raddr + 40'(8 * rbeat));
        app_rd_data_end_i   = (rbeat == 7);
        rbeat++;
        if (rbeat == 8) ractive = 1'b0;
      end else begin
        app_rd_data_valid_i = 1'b0;
        app_rd_data_end_i   = 1'b0;
      end
    end
  end

  // Response consumer.
  initial begin
    mem_resp_header_yumi_i = 1'b0;
    mem_resp_data_yumi_i   = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      mem_resp_header_yumi_i = mem_resp_header_v_o & hy_en;
      mem_resp_data_yumi_i   = mem_resp_data_v_o & dy_en;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic send_hdr(input bedrock_msg_e t, input logic [2:0] sz, input logic [39:0] a);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    mem_cmd_header_i   = mkhdr(t, sz, a);
    mem_cmd_header_v_i = 1'b1;
    @(negedge clk_i);
    while (!mem_cmd_header_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check_eq("hdr_accept_timeout", 64'(n), 64'(0));
    @(posedge clk_i); #1;
    mem_cmd_header_v_i = 1'b0;
  endtask

  task automatic send_data(input logic [63:0] d);
    int n;
    n = 0;
    mem_cmd_data_i   = d;
    mem_cmd_data_v_i = 1'b1;
    @(negedge clk_i);
    while (!mem_cmd_data_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check_eq("data_accept_timeout", 64'(n), 64'(0));
    @(posedge clk_i); #1;
    mem_cmd_data_v_i = 1'b0;
  endtask

  task automatic wait_rsp(input int ndata, input int nhdr);
    int n;
    n = 0;
    while ((rdat.size() < ndata || rhdr.size() < nhdr) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 1000) check_eq("resp_timeout", 64'(rdat.size()), 64'(ndata));
  endtask

  task automatic clear_logs();
    rdat.delete(); rhdr.delete(); hdr_cyc.delete(); wbeats.delete();
  endtask

  initial begin
    reset_i = 1'b1;
    mem_cmd_header_i = '0; mem_cmd_header_v_i = 1'b0;
    mem_cmd_data_i = '0; mem_cmd_data_v_i = 1'b0;
    app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1;
    #2;
    check_eq("reset_outputs", 64'({mem_cmd_header_ready_o, mem_resp_header_v_o, mem_resp_data_v_o,
                                   app_en_o, app_wdf_wren_o, app_wdf_end_o, mem_cmd_data_ready_o}), 64'(0));
    check_eq("reset_credits", 64'(dut.u_rd_return.credits_o), 64'(16));
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_hdr_ready", 64'(mem_cmd_header_ready_o), 64'(1));

    // A: cached 64B read, eight beats in order.
    send_hdr(e_bedrock_mem_rd, 3'd6, 40'h1000);
    @(negedge clk_i);
    check_eq("rdA_app_en_next", 64'({app_en_o, app_cmd_o}), 64'({1'b1, e_read}));
    check_eq("rdA_app_addr", 64'(app_addr_o), 64'h1000);
    wait_rsp(8, 1);
    check_eq("rdA_hdr", 64'(rhdr[0]), 64'(mkhdr(e_bedrock_mem_rd, 3'd6, 40'h1000)));
    for (int k = 0; k < 8; k++) check_eq($sformatf("rdA_data%0d", k), rdat[k], pat(40'h1000 + 40'(8 * k)));
    repeat (5) @(negedge clk_i);
    check_eq("rdA_hdr_once", 64'(rhdr.size()), 64'(1));
    check_eq("rdA_credits", 64'(dut.u_rd_return.credits_o), 64'(16));
    clear_logs();

    // B: uncached 8B read, one beat kept, no write data.
    send_hdr(e_bedrock_mem_uc_rd, 3'd3, 40'h1100);
    wait_rsp(1, 1);
    repeat (20) @(negedge clk_i);
    check_eq("rdB_beats", 64'(rdat.size()), 64'(1));
    check_eq("rdB_data", rdat[0], pat(40'h1100));
    check_eq("rdB_no_wdf", 64'(wbeats.size()), 64'(0));
    check_eq("rdB_credits", 64'(dut.u_rd_return.credits_o), 64'(16));
    clear_logs();

    // C: uncached 8B write, one data beat plus seven pad beats.
    send_hdr(e_bedrock_mem_uc_wr, 3'd3, 40'h2000);
    send_data(64'hDEAD_BEEF_0123_4567);
    wait_rsp(0, 1);
    check_eq("wrC_beats", 64'(wbeats.size()), 64'(8));
    check_eq("wrC_b0", {wbeats[0].d}, 64'hDEAD_BEEF_0123_4567);
    check_eq("wrC_b0_mask_end", 64'({wbeats[0].m, wbeats[0].e}), 64'({8'h00, 1'b0}));
    check_eq("wrC_pad1", 64'({wbeats[1].d, wbeats[1].m, wbeats[1].e}), 64'({64'h0, 8'hFF, 1'b0}));
    check_eq("wrC_pad6_end", 64'({wbeats[6].m, wbeats[6].e}), 64'({8'hFF, 1'b0}));
    check_eq("wrC_last", 64'({wbeats[7].m, wbeats[7].e}), 64'({8'hFF, 1'b1}));
    check_eq("wrC_ack_hdr", 64'(rhdr[0]), 64'(mkhdr(e_bedrock_mem_uc_wr, 3'd3, 40'h2000)));
    check_eq("wrC_ack_timing", 64'(hdr_cyc[0]), 64'(end_cyc + 1));
    clear_logs();

    // D: four 64B reads with data consumption held off; third stalls on credits.
    hy_en = 1'b1; dy_en = 1'b0;
    begin
      int rd0;
      rd0 = rd_cmds;
      fork
        for (int i = 0; i < 4; i++) send_hdr(e_bedrock_mem_rd, 3'd6, 40'h3000 + 40'(64 * i));
      join_none
      repeat (60) @(negedge clk_i);
      check_eq("rdD_issued", 64'(rd_cmds - rd0), 64'(2));
      check_eq("rdD_stall_en", 64'(app_en_o), 64'(0));
      check_eq("rdD_credits0", 64'(dut.u_rd_return.credits_o), 64'(0));
      check_eq("rdD_one_hdr", 64'(rhdr.size()), 64'(1));
      dy_en = 1'b1;
      wait_rsp(32, 4);
      check_eq("rdD_issued_all", 64'(rd_cmds - rd0), 64'(4));
    end
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("rdD_hdr%0d", i), 64'(rhdr[i]), 64'(mkhdr(e_bedrock_mem_rd, 3'd6, 40'h3000 + 40'(64 * i))));
    for (int k = 0; k < 32; k++) check_eq($sformatf("rdD_data%0d", k), rdat[k], pat(40'h3000 + 40'(8 * k)));
    repeat (5) @(negedge clk_i);
    check_eq("rdD_credits_back", 64'(dut.u_rd_return.credits_o), 64'(16));
    clear_logs();

    // E: 64B write then read of the same line.
    send_hdr(e_bedrock_mem_wr, 3'd6, 40'h4000);
    for (int k = 0; k < 8; k++) send_data({32'hA0B0C0D0, 32'(k)});
    send_hdr(e_bedrock_mem_rd, 3'd6, 40'h4000);
    wait_rsp(8, 2);
    check_eq("wrE_mask0", 64'({wbeats[0].m, wbeats[7].m}), 64'(0));
    check_eq("wrE_end", 64'({wbeats[6].e, wbeats[7].e}), 64'({1'b0, 1'b1}));
    check_eq("wrE_ack_first", 64'(rhdr[0]), 64'(mkhdr(e_bedrock_mem_wr, 3'd6, 40'h4000)));
    check_eq("rdE_hdr_second", 64'(rhdr[1]), 64'(mkhdr(e_bedrock_mem_rd, 3'd6, 40'h4000)));
    for (int k = 0; k < 8; k++) check_eq($sformatf("rdE_data%0d", k), rdat[k], {32'hA0B0C0D0, 32'(k)});
    clear_logs();

    // F: asynchronous reset in the middle of a write pad.
    send_hdr(e_bedrock_mem_uc_wr, 3'd3, 40'h5000);
    send_data(64'h1234_5678_9ABC_DEF0);
    check_eq("rstF_in_pad", 64'({app_wdf_wren_o, app_wdf_mask_o}), 64'({1'b1, 8'hFF}));
    @(posedge clk_i); #2;
    reset_i = 1'b1;
    #1;
    check_eq("rstF_outputs", 64'({mem_cmd_header_ready_o, mem_resp_header_v_o, mem_resp_data_v_o,
                                  app_en_o, app_wdf_wren_o, app_wdf_end_o, mem_cmd_data_ready_o}), 64'(0));
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check_eq("rstF_state_idle", 64'(dut.state_q), 64'(e_idle));
    check_eq("rstF_ready", 64'({mem_cmd_header_ready_o, app_wdf_wren_o}), 64'({1'b1, 1'b0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
